// File: rtl/decoder_stream.sv
// decoder_stream: streaming instruction decoder for a tiny-gpu core.
// Raw instructions arrive on a valid/ready stream from the fetcher. Decoded
// bundles leave on a valid/ready stream towards the issue/execute units.
// A two-deep buffer (output register O plus skid register S) keeps in_ready
// purely registered, so it has no combinational path from out_ready.
// Optional build macro: DECODER_STATS_EN adds saturating handshake counters
// (stat_decoded, stat_illegal). Without it those ports and their logic are absent.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holding valid must keep its
// payload stable until the transfer. in_ready depends only on skid occupancy,
// so the fetcher can rely on it without seeing out_ready.
//
// Parameter legality: INSTR_BITS == 4 + 3*REG_ADDR_BITS, REG_ADDR_BITS >= 3,
// IMM_BITS <= 2*REG_ADDR_BITS.
module decoder_stream #(
  parameter int INSTR_BITS    = 16,
  parameter int REG_ADDR_BITS = 4,
  parameter int IMM_BITS      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_BITS-1:0]    instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_ADDR_BITS-1:0] decoded_rd_address,
  output logic [REG_ADDR_BITS-1:0] decoded_rs_address,
  output logic [REG_ADDR_BITS-1:0] decoded_rt_address,
  output logic [2:0]               decoded_nzp,
  output logic [IMM_BITS-1:0]      decoded_immediate,
  output logic                     decoded_reg_write_enable,
  output logic                     decoded_mem_read_enable,
  output logic                     decoded_mem_write_enable,
  output logic                     decoded_nzp_write_enable,
  output logic [1:0]               decoded_reg_input_mux,
  output logic [2:0]               decoded_alu_arithmetic_mux,
  output logic                     decoded_alu_output_mux,
  output logic                     decoded_pc_mux,
  output logic                     decoded_ret,
  output logic                     decoded_illegal
`ifdef DECODER_STATS_EN
  ,
  output logic [31:0]              stat_decoded,
  output logic [15:0]              stat_illegal
`endif
);

  // Opcode encoding carried in the top four instruction bits.
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_BRNZP = 4'h1,
    OP_CMP   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_MUL   = 4'h5,
    OP_DIV   = 4'h6,
    OP_LDR   = 4'h7,
    OP_STR   = 4'h8,
    OP_CONST = 4'h9,
    OP_AND   = 4'hA,
    OP_OR    = 4'hB,
    OP_XOR   = 4'hC,
    OP_SHL   = 4'hD,
    OP_ILL   = 4'hE,
    OP_RET   = 4'hF
  } opcode_t;

  // Register write source selections.
  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IMM = 2'b10;

  // One complete decoded bundle, as held in O and S.
  typedef struct packed {
    logic [REG_ADDR_BITS-1:0] rd;
    logic [REG_ADDR_BITS-1:0] rs;
    logic [REG_ADDR_BITS-1:0] rt;
    logic [2:0]               nzp;
    logic [IMM_BITS-1:0]      imm;
    logic                     reg_we;
    logic                     mem_re;
    logic                     mem_we;
    logic                     nzp_we;
    logic [1:0]               reg_mux;
    logic [2:0]               arith;
    logic                     alu_out;
    logic                     pc_mux;
    logic                     ret;
    logic                     illegal;
  } bundle_t;

  opcode_t w_opcode;
  bundle_t w_dec;
  logic    w_accept;
  logic    w_o_free;
  logic    w_handshake;

  bundle_t r_o;
  bundle_t r_s;
  logic    r_o_valid;
  logic    r_s_valid;

  assign w_opcode = opcode_t'(instruction[INSTR_BITS-1 -: 4]);

  // Combinational decode of the incoming instruction; fields are always sliced.
  always_comb begin
    w_dec         = '0;
    w_dec.rd      = instruction[INSTR_BITS-5 -: REG_ADDR_BITS];
    w_dec.rs      = instruction[INSTR_BITS-5-REG_ADDR_BITS -: REG_ADDR_BITS];
    w_dec.rt      = instruction[REG_ADDR_BITS-1:0];
    w_dec.nzp     = instruction[INSTR_BITS-5 -: 3];
    w_dec.imm     = instruction[IMM_BITS-1:0];
    case (w_opcode)
      OP_NOP: ;
      OP_BRNZP: w_dec.pc_mux = 1'b1;
      OP_CMP: begin
        w_dec.alu_out = 1'b1;
        w_dec.nzp_we  = 1'b1;
      end
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_AND, OP_OR, OP_XOR, OP_SHL: begin
        w_dec.reg_we  = 1'b1;
        w_dec.reg_mux = MUX_ALU;
        // The low three opcode bits, rebased, give the ALU operation.
        w_dec.arith   = 3'(w_opcode - OP_ADD);
        if (w_opcode >= OP_AND) w_dec.arith = 3'(w_opcode - OP_AND) | 3'b100;
      end
      OP_LDR: begin
        w_dec.reg_we  = 1'b1;
        w_dec.mem_re  = 1'b1;
        w_dec.reg_mux = MUX_MEM;
      end
      OP_STR: w_dec.mem_we = 1'b1;
      OP_CONST: begin
        w_dec.reg_we  = 1'b1;
        w_dec.reg_mux = MUX_IMM;
      end
      OP_RET: w_dec.ret = 1'b1;
      default: w_dec.illegal = 1'b1;
    endcase
  end

  // Transfer qualifiers: accept depends only on skid occupancy.
  always_comb begin
    w_accept    = in_valid && !r_s_valid;
    w_o_free    = !r_o_valid || out_ready;
    w_handshake = r_o_valid && out_ready;
  end

  // Occupancy of O and S; flush wins over any same-cycle accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_o_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (flush) begin
      r_o_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (w_o_free) begin
      if (r_s_valid) begin
        r_o_valid <= 1'b1;
        r_s_valid <= 1'b0;
      end else begin
        r_o_valid <= w_accept;
      end
    end else if (w_accept) begin
      r_s_valid <= 1'b1;
    end
  end

  // Bundle payloads: O refills from S first, else from the input; S catches
  // an accept while O is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_o <= '0;
      r_s <= '0;
    end else if (!flush) begin
      if (w_o_free) begin
        if (r_s_valid) r_o <= r_s;
        else if (w_accept) r_o <= w_dec;
      end else if (w_accept) begin
        r_s <= w_dec;
      end
    end
  end

  assign in_ready                   = !r_s_valid;
  assign out_valid                  = r_o_valid;
  assign decoded_rd_address         = r_o.rd;
  assign decoded_rs_address         = r_o.rs;
  assign decoded_rt_address         = r_o.rt;
  assign decoded_nzp                = r_o.nzp;
  assign decoded_immediate          = r_o.imm;
  assign decoded_reg_write_enable   = r_o.reg_we;
  assign decoded_mem_read_enable    = r_o.mem_re;
  assign decoded_mem_write_enable   = r_o.mem_we;
  assign decoded_nzp_write_enable   = r_o.nzp_we;
  assign decoded_reg_input_mux      = r_o.reg_mux;
  assign decoded_alu_arithmetic_mux = r_o.arith;
  assign decoded_alu_output_mux     = r_o.alu_out;
  assign decoded_pc_mux             = r_o.pc_mux;
  assign decoded_ret                = r_o.ret;
  assign decoded_illegal            = r_o.illegal;

`ifdef DECODER_STATS_EN
  logic [31:0] r_stat_decoded;
  logic [15:0] r_stat_illegal;

  // Saturating output-handshake counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_decoded <= '0;
      r_stat_illegal <= '0;
    end else if (w_handshake) begin
      if (r_stat_decoded != '1) r_stat_decoded <= r_stat_decoded + 32'd1;
      if (r_o.illegal && (r_stat_illegal != '1)) r_stat_illegal <= r_stat_illegal + 16'd1;
    end
  end

  assign stat_decoded = r_stat_decoded;
  assign stat_illegal = r_stat_illegal;
`else
  // Handshake qualifier only feeds the statistics counters.
  logic w_unused_handshake;
  assign w_unused_handshake = w_handshake;
`endif

endmodule

// File: tb/tb_decoder_stream.sv
// Testbench for decoder_stream: directed steps plus a randomized phase, all
// checked against an in-order queue of accepted instructions and a 16-entry
// control table built from the opcode map.
module tb_decoder_stream;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] instruction;
  logic [3:0]  rd, rs, rt;
  logic [2:0]  nzp;
  logic [7:0]  imm;
  logic        rwe, mre, mwe, nwe;
  logic [1:0]  rmux;
  logic [2:0]  arith;
  logic        aom, pcm, ret, ill;
`ifdef DECODER_STATS_EN
  logic [31:0] stat_decoded;
  logic [15:0] stat_illegal;
`endif

  decoder_stream dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .decoded_rd_address(rd), .decoded_rs_address(rs), .decoded_rt_address(rt),
    .decoded_nzp(nzp), .decoded_immediate(imm),
    .decoded_reg_write_enable(rwe), .decoded_mem_read_enable(mre),
    .decoded_mem_write_enable(mwe), .decoded_nzp_write_enable(nwe),
    .decoded_reg_input_mux(rmux), .decoded_alu_arithmetic_mux(arith),
    .decoded_alu_output_mux(aom), .decoded_pc_mux(pcm),
    .decoded_ret(ret), .decoded_illegal(ill)
`ifdef DECODER_STATS_EN
    , .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          step_no   = 0;
  logic [15:0] exp_q[$];
  logic [12:0] ctrl_tbl[16];
  int          exp_stat_dec = 0;
  int          exp_stat_ill = 0;

  wire [35:0] w_got = {rd, rs, rt, nzp, imm, rwe, mre, mwe, nwe, rmux, arith, aom, pcm, ret, ill};

  // Control word layout: {reg_we, mem_re, mem_we, nzp_we, mux[1:0], arith[2:0], alu_out, pc, ret, illegal}
  function automatic logic [12:0] mk(bit rw, bit mr, bit mw, bit nw, bit [1:0] mx,
                                     bit [2:0] ar, bit ao, bit pc, bit rt_b, bit il);
    return {rw, mr, mw, nw, mx, ar, ao, pc, rt_b, il};
  endfunction

  function automatic logic [35:0] expect_bundle(logic [15:0] i);
    return {i[11:8], i[7:4], i[3:0], i[11:9], i[7:0], ctrl_tbl[i[15:12]]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s (step %0d): got %0h expected %0h", tag, step_no, got, exp);
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    if (exp_q.size() > 0) check("bundle", 64'(w_got), 64'(expect_bundle(exp_q[0])));
`ifdef DECODER_STATS_EN
    check("stat_decoded", 64'(stat_decoded), 64'(exp_stat_dec));
    check("stat_illegal", 64'(stat_illegal), 64'(exp_stat_ill));
`endif
  endtask

  // Driver: one clock of stimulus, model update, then output checks.
  task automatic step(input logic v, input logic [15:0] ins, input logic ordy,
                      input logic fl, output logic acc);
    logic hs;
    in_valid    = v;
    instruction = ins;
    out_ready   = ordy;
    flush       = fl;
    acc = v && (exp_q.size() < 2) && !fl;
    hs  = (exp_q.size() > 0) && ordy;
    if (hs) begin
      exp_stat_dec++;
      if (ctrl_tbl[exp_q[0][15:12]][0]) exp_stat_ill++;
    end
    @(posedge clk);
    #1;
    step_no++;
    if (fl) exp_q.delete();
    else begin
      if (hs) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ins);
    end
    check_outputs();
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_stat_dec = 0;
    exp_stat_ill = 0;
  endtask

  logic        acc;
  logic [15:0] ins;
  int          tries;

  initial begin
    // Reference control table from the opcode map
    for (int op = 0; op < 16; op++) ctrl_tbl[op] = '0;
    ctrl_tbl[1]  = mk(0, 0, 0, 0, 2'b00, 3'd0, 0, 1, 0, 0);
    ctrl_tbl[2]  = mk(0, 0, 0, 1, 2'b00, 3'd0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      ctrl_tbl[3 + k]  = mk(1, 0, 0, 0, 2'b00, 3'(k), 0, 0, 0, 0);
      ctrl_tbl[10 + k] = mk(1, 0, 0, 0, 2'b00, 3'(4 + k), 0, 0, 0, 0);
    end
    ctrl_tbl[7]  = mk(1, 1, 0, 0, 2'b01, 3'd0, 0, 0, 0, 0);
    ctrl_tbl[8]  = mk(0, 0, 1, 0, 2'b00, 3'd0, 0, 0, 0, 0);
    ctrl_tbl[9]  = mk(1, 0, 0, 0, 2'b10, 3'd0, 0, 0, 0, 0);
    ctrl_tbl[14] = mk(0, 0, 0, 0, 2'b00, 3'd0, 0, 0, 0, 1);
    ctrl_tbl[15] = mk(0, 0, 0, 0, 2'b00, 3'd0, 0, 0, 1, 0);

    // Reset state
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_bundle", 64'(w_got), 64'd0);
    reset = 1'b0;
    model_reset();

    // First instruction: ADD r1, r2, r3
    step(1'b1, 16'h3123, 1'b1, 1'b0, acc);
    check("add_rd", 64'(rd), 64'd1);
    check("add_rs", 64'(rs), 64'd2);
    check("add_rt", 64'(rt), 64'd3);
    check("add_rwe", 64'(rwe), 64'd1);
    check("add_arith", 64'(arith), 64'd0);
    check("add_mux", 64'(rmux), 64'd0);

    // Opcode sweep with full throughput
    for (int op = 0; op < 16; op++) begin
      ins = {4'(op), 12'($urandom_range(0, 4095))};
      if (op == 12) ins = 16'hC456;
      if (op == 9)  ins = 16'h9A7F;
      if (op == 14) ins = 16'hE000;
      if (op == 1)  ins = 16'h1E05;
      step(1'b1, ins, 1'b1, 1'b0, acc);
      if (op == 12) check("xor_arith", 64'(arith), 64'd6);
      if (op == 9) begin
        check("const_rwe", 64'(rwe), 64'd1);
        check("const_mux", 64'(rmux), 64'd2);
        check("const_imm", 64'(imm), 64'h7F);
      end
      if (op == 14) begin
        check("ill_flag", 64'(ill), 64'd1);
        check("ill_ctrl", 64'({rwe, mre, mwe, nwe, rmux, arith, aom, pcm, ret}), 64'd0);
      end
      if (op == 1) begin
        check("br_pc", 64'(pcm), 64'd1);
        check("br_nzp", 64'(nzp), 64'd7);
      end
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, acc);

    // Backpressure: A into O, B into S, C held off
    step(1'b1, 16'h3A11, 1'b0, 1'b0, acc);
    step(1'b1, 16'hB2C3, 1'b0, 1'b0, acc);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 16'h7456, 1'b0, 1'b0, acc);
    check("bp_c_held", 64'(acc), 64'd0);
    check("bp_o_is_a", 64'(w_got), 64'(expect_bundle(16'h3A11)));
    tries = 0;
    do begin
      step(1'b1, 16'h7456, 1'b1, 1'b0, acc);
      tries++;
    end while (!acc && tries < 6);
    check("bp_c_accepted", 64'(acc), 64'd1);
    step(1'b0, 16'h0, 1'b1, 1'b0, acc);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Flush with O and S full and a same-cycle input
    step(1'b1, 16'h4111, 1'b0, 1'b0, acc);
    step(1'b1, 16'h5222, 1'b0, 1'b0, acc);
    step(1'b1, 16'h6333, 1'b0, 1'b1, acc);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    // Flush while an accept would otherwise happen: input dropped
    step(1'b1, 16'h8444, 1'b0, 1'b0, acc);
    step(1'b1, 16'h9555, 1'b1, 1'b1, acc);
    check("flush_drop", 64'(out_valid), 64'd0);
    repeat (2) step(1'b0, 16'h0, 1'b1, 1'b0, acc);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0), acc);
    end

    // Asynchronous reset mid-stream
    step(1'b1, 16'hA123, 1'b0, 1'b0, acc);
    step(1'b1, 16'hD456, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("areset_out_valid", 64'(out_valid), 64'd0);
    check("areset_in_ready", 64'(in_ready), 64'd1);
    check("areset_bundle", 64'(w_got), 64'd0);
`ifdef DECODER_STATS_EN
    check("areset_stat_dec", 64'(stat_decoded), 64'd0);
    check("areset_stat_ill", 64'(stat_illegal), 64'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Post-reset stream: 5 legal and 2 illegal handshakes, then flush
    step(1'b1, 16'h3123, 1'b1, 1'b0, acc);
    check("post_rst_bundle", 64'(w_got), 64'(expect_bundle(16'h3123)));
    step(1'b1, 16'h9A7F, 1'b1, 1'b0, acc);
    step(1'b1, 16'hE000, 1'b1, 1'b0, acc);
    step(1'b1, 16'hC456, 1'b1, 1'b0, acc);
    step(1'b1, 16'hE123, 1'b1, 1'b0, acc);
    step(1'b1, 16'h7111, 1'b1, 1'b0, acc);
    step(1'b1, 16'h1E05, 1'b1, 1'b0, acc);
    step(1'b0, 16'h0, 1'b1, 1'b0, acc);
    step(1'b1, 16'h3333, 1'b0, 1'b1, acc);
`ifdef DECODER_STATS_EN
    check("stats_decoded_7", 64'(stat_decoded), 64'd7);
    check("stats_illegal_2", 64'(stat_illegal), 64'd2);
`endif
    check("final_idle", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decoder_stream.md
Name: decoder_stream

Overview:
- Parametrised next-generation instruction decoder for a tiny-gpu core.
- Replaces state-gated decoding with a valid/ready stream between fetcher and issue/execute.
- Has a 2-entry skid buffer, extended ALU opcodes, illegal-opcode detection and a flush input.
- Sits between the fetcher and the per-thread ALU/LSU/PC units, one per core.

Parameters:
- INSTR_BITS, 16, instruction width; must equal 4 + 3*REG_ADDR_BITS.
- REG_ADDR_BITS, 4, register address width; must be >= 3.
- IMM_BITS, 8, immediate width; must be <= 2*REG_ADDR_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all buffered decodes (branch redirect)
- in_valid  in  1  fetcher has an instruction
- in_ready  out  1  decoder can accept this cycle
- instruction  in  INSTR_BITS  raw instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts bundle
- decoded_rd_address, decoded_rs_address, decoded_rt_address  out  REG_ADDR_BITS each  register fields
- decoded_nzp  out  3  branch condition
- decoded_immediate  out  IMM_BITS  immediate
- decoded_reg_write_enable, decoded_mem_read_enable, decoded_mem_write_enable, decoded_nzp_write_enable  out  1 each  control enables
- decoded_reg_input_mux  out  2  register write source: 00 ALU, 01 memory, 10 immediate
- decoded_alu_arithmetic_mux  out  3  ALU operation: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 SHL
- decoded_alu_output_mux  out  1  1 = compare result to NZP
- decoded_pc_mux  out  1  1 = branch
- decoded_ret  out  1  thread return
- decoded_illegal  out  1  opcode unassigned

Behaviour:
- Field slicing, MSB down:
  - opcode [INSTR_BITS-1 -: 4]
  - rd: next REG_ADDR_BITS
  - rs: next REG_ADDR_BITS
  - rt: low REG_ADDR_BITS
  - nzp: top 3 bits of the rd field
  - immediate: low IMM_BITS
- Fields are always extracted, regardless of opcode.
- Opcode map:
  - 0 NOP, 1 BRnzp (pc_mux), 2 CMP (alu_output_mux, nzp_write)
  - 3–6 ADD/SUB/MUL/DIV (reg_write, mux 00, arith 000–011)
  - 7 LDR (reg_write, mem_read, mux 01), 8 STR (mem_write), 9 CONST (reg_write, mux 10)
  - A/B/C/D AND/OR/XOR/SHL (reg_write, mux 00, arith 100–111)
  - F RET
  - E illegal: every enable, mux, pc_mux and ret forced 0; decoded_illegal=1; fields still passed.
- Control signals not set by an opcode are 0.
- Handshake and buffering:
  - Accept when in_valid && in_ready.
  - Output register (O) plus skid register (S).
  - Latency: the decoded bundle appears on outputs the cycle after acceptance.
  - in_ready = !S_valid; it is a registered signal with no combinational path from out_ready.
  - Output handshake completes on out_valid && out_ready; O refills from S if S is valid, else from the input if accepted the same cycle.
  - Accepted while O is valid and not draining: the bundle goes to S.
  - Bundles stay stable while out_valid && !out_ready.
  - Order is strictly FIFO. Full throughput is 1/cycle while out_ready=1.
- flush:
  - Clears O_valid and S_valid next edge; in_ready=1 afterwards.
  - Flush has priority over a same-cycle accept; that input is dropped.
- reset (async):
  - All outputs 0, out_valid=0, S_valid=0, in_ready=1 immediately.
  - Mid-stream data is lost. The first accept is allowed on the first edge after deassertion.

Optional Feature:
- DECODER_STATS_EN defined:
  - Adds outputs stat_decoded (32) and stat_illegal (16).
  - Each counts output handshakes (illegal = handshake with decoded_illegal=1).
  - Counters saturate at all-ones and are cleared by reset, not by flush.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1 instruction=16'h3123 with out_ready=1:
  - next cycle out_valid=1, rd=1, rs=2, rt=3, reg_write=1, arith=000, mux=00.
- Sweep all 16 opcodes, including 16'hC456 (XOR) and 16'h9A7F (CONST):
  - XOR: arith=110.
  - CONST: reg_write=1, mux=10, imm=8'h7F.
  - 16'hE000: illegal=1 with all enables 0.
  - 16'h1E05: pc_mux=1, nzp=3'b111.
- Backpressure: out_ready=0, stream A,B,C:
  - O=A, S=B, in_ready=0, C held.
  - Release: A,B,C emerge in order with no loss or duplication.
- flush with O and S full plus a same-cycle in_valid:
  - next cycle out_valid=0, in_ready=1; the input is not output.
- Assert reset asynchronously between edges mid-stream:
  - outputs clear before the next clk edge; first post-reset instruction decodes correctly.
- DECODER_STATS_EN: 5 legal + 2 illegal handshakes:
  - stat_decoded=7, stat_illegal=2; unchanged across flush.
